veri_bellek_hakemi: RTL and testbench

- Two-requester arbiter and sequencer for the single data-memory port.
- Requester 0 is the bellek islem birimi (bib_* bus); requester 1 is a secondary master, e.g. cache refill or debug.
- Grants round-robin, registers and issues one transaction at a time, tracks the outstanding response with a timeout, and returns data/stall on the requesters' bib-style durdur/veri interface.

---
 rtl/veri_bellek_hakemi_pkg.sv | 25 ++
 rtl/veri_bellek_hakemi_oncelik.sv | 31 +++
 rtl/veri_bellek_hakemi.sv | 173 +++++++++++++++++
 tb/tb_veri_bellek_hakemi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/veri_bellek_hakemi_pkg.sv
// ============================================================================
// Module : veri_bellek_hakemi_pkg
// Brief  : Shared state encodings, requester ids and constants for the
//          data-memory port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package veri_bellek_hakemi_pkg;

    typedef enum logic [1:0] {
        HKM_BOSTA = 2'd0,
        HKM_ISTEK = 2'd1,
        HKM_YANIT = 2'd2
    } hkm_durum_e;

    localparam logic HKM_IST0 = 1'b0;
    localparam logic HKM_IST1 = 1'b1;

    // Read data handed back to the owner when a transaction times out.
    localparam logic [31:0] HKM_HATA_VERI = 32'h0;

endpackage

`default_nettype wire

// File: rtl/veri_bellek_hakemi_oncelik.sv
// ============================================================================
// Module : hakem_oncelik_secici
// Brief  : Combinational two-way round-robin pick; oncelik names the
//          requester that wins when both ask at once.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hakem_oncelik_secici
    import veri_bellek_hakemi_pkg::*;
(
    input  logic       sec0_i,
    input  logic       sec1_i,
    input  logic       oncelik_i,
    output logic       secilen_o,
    output logic       gecerli_o
);

    always_comb begin
        secilen_o = HKM_IST0;
        gecerli_o = sec0_i | sec1_i;
        if (sec0_i && sec1_i) begin
            secilen_o = oncelik_i;
        end else if (sec1_i) begin
            secilen_o = HKM_IST1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/veri_bellek_hakemi.sv
// ============================================================================
// Module : veri_bellek_hakemi
// Brief  : Two-requester round-robin arbiter/sequencer for the single
//          data-memory port, with response timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module veri_bellek_hakemi
    import veri_bellek_hakemi_pkg::*;
#(
    parameter int ZAMAN_ASIMI = 64,
    parameter int ADR_W       = 32,
    parameter int VERI_W      = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                ist0_sec_i,
    input  logic [ADR_W-1:0]    ist0_adr_i,
    input  logic [VERI_W-1:0]   ist0_veri_i,
    input  logic [VERI_W/8-1:0] ist0_maske_i,
    output logic [VERI_W-1:0]   ist0_veri_o,
    output logic                ist0_durdur_o,

    input  logic                ist1_sec_i,
    input  logic [ADR_W-1:0]    ist1_adr_i,
    input  logic [VERI_W-1:0]   ist1_veri_i,
    input  logic [VERI_W/8-1:0] ist1_maske_i,
    output logic [VERI_W-1:0]   ist1_veri_o,
    output logic                ist1_durdur_o,

    output logic                bellek_istek_o,
    output logic [ADR_W-1:0]    bellek_adr_o,
    output logic [VERI_W-1:0]   bellek_veri_o,
    output logic [VERI_W/8-1:0] bellek_maske_o,
    input  logic                bellek_kabul_i,
    input  logic                bellek_yanit_i,
    input  logic [VERI_W-1:0]   bellek_veri_i,

    output logic                hata_o
);

    localparam int                 c_MASKE_W   = VERI_W / 8;
    localparam int                 c_SAYAC_W   = $clog2(ZAMAN_ASIMI);
    localparam logic [c_SAYAC_W-1:0] c_SAYAC_SON = c_SAYAC_W'(ZAMAN_ASIMI - 1);
    localparam logic [VERI_W-1:0]  c_HATA_VERI = VERI_W'(HKM_HATA_VERI);

    hkm_durum_e             durum_q, durum_d;
    logic                   sahip_q, sahip_d;
    logic                   oncelik_q, oncelik_d;
    logic [c_SAYAC_W-1:0]   sayac_q, sayac_d;
    logic                   istek_q, istek_d;
    logic [ADR_W-1:0]       adr_q, adr_d;
    logic [VERI_W-1:0]      veri_q, veri_d;
    logic [c_MASKE_W-1:0]   maske_q, maske_d;

    logic                   w_secilen;
    logic                   w_gecerli;
    logic                   w_sahip_sec;
    logic                   w_tamam;
    logic                   w_hata;
    logic [VERI_W-1:0]      w_donus_veri;

    hakem_oncelik_secici u_secici (
        .sec0_i    (ist0_sec_i),
        .sec1_i    (ist1_sec_i),
        .oncelik_i (oncelik_q),
        .secilen_o (w_secilen),
        .gecerli_o (w_gecerli)
    );

    assign w_sahip_sec = (sahip_q == HKM_IST1) ? ist1_sec_i : ist0_sec_i;

    always_comb begin
        durum_d   = durum_q;
        sahip_d   = sahip_q;
        oncelik_d = oncelik_q;
        sayac_d   = sayac_q;
        istek_d   = istek_q;
        adr_d     = adr_q;
        veri_d    = veri_q;
        maske_d   = maske_q;
        w_tamam   = 1'b0;
        w_hata    = 1'b0;

        case (durum_q)
            HKM_BOSTA: begin
                if (w_gecerli) begin
                    sahip_d = w_secilen;
                    adr_d   = (w_secilen == HKM_IST1) ? ist1_adr_i   : ist0_adr_i;
                    veri_d  = (w_secilen == HKM_IST1) ? ist1_veri_i  : ist0_veri_i;
                    maske_d = (w_secilen == HKM_IST1) ? ist1_maske_i : ist0_maske_i;
                    istek_d = 1'b1;
                    durum_d = HKM_ISTEK;
                end
            end
            HKM_ISTEK: begin
                // Acceptance wins over a simultaneous withdrawal: memory already owns it.
                if (bellek_kabul_i) begin
                    istek_d = 1'b0;
                    if (bellek_yanit_i) begin
                        w_tamam = 1'b1;
                        durum_d = HKM_BOSTA;
                    end else begin
                        sayac_d = '0;
                        durum_d = HKM_YANIT;
                    end
                end else if (!w_sahip_sec) begin
                    istek_d = 1'b0;
                    durum_d = HKM_BOSTA;
                end
            end
            HKM_YANIT: begin
                sayac_d = sayac_q + 1'b1;
                if (bellek_yanit_i) begin
                    w_tamam = 1'b1;
                    durum_d = HKM_BOSTA;
                end else if (sayac_q == c_SAYAC_SON) begin
                    w_tamam = 1'b1;
                    w_hata  = 1'b1;
                    durum_d = HKM_BOSTA;
                end
            end
            default: begin
                istek_d = 1'b0;
                durum_d = HKM_BOSTA;
            end
        endcase

        if (w_tamam) begin
            oncelik_d = ~sahip_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q   <= HKM_BOSTA;
            sahip_q   <= HKM_IST0;
            oncelik_q <= HKM_IST0;
            sayac_q   <= '0;
            istek_q   <= 1'b0;
            adr_q     <= '0;
            veri_q    <= '0;
            maske_q   <= '0;
        end else begin
            durum_q   <= durum_d;
            sahip_q   <= sahip_d;
            oncelik_q <= oncelik_d;
            sayac_q   <= sayac_d;
            istek_q   <= istek_d;
            adr_q     <= adr_d;
            veri_q    <= veri_d;
            maske_q   <= maske_d;
        end
    end

    assign w_donus_veri = w_hata ? c_HATA_VERI : bellek_veri_i;

    assign ist0_durdur_o = ist0_sec_i & ~(w_tamam & (sahip_q == HKM_IST0));
    assign ist1_durdur_o = ist1_sec_i & ~(w_tamam & (sahip_q == HKM_IST1));
    assign ist0_veri_o   = (w_tamam && sahip_q == HKM_IST0) ? w_donus_veri : '0;
    assign ist1_veri_o   = (w_tamam && sahip_q == HKM_IST1) ? w_donus_veri : '0;

    assign bellek_istek_o = istek_q;
    assign bellek_adr_o   = adr_q;
    assign bellek_veri_o  = veri_q;
    assign bellek_maske_o = maske_q;
    assign hata_o         = w_hata;

endmodule

`default_nettype wire

// File: tb/tb_veri_bellek_hakemi.sv
// ============================================================================
// Module : tb_veri_bellek_hakemi
// Brief  : Directed, table-driven bench for veri_bellek_hakemi.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_veri_bellek_hakemi;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0, s1, kab, yan;
    logic [31:0] a0, a1, d0, d1, md;
    logic [3:0]  m0, m1;
    logic [31:0] v0, v1, badr, bveri;
    logic [3:0]  bmaske;
    logic        dd0, dd1, bist, hata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    veri_bellek_hakemi #(.ZAMAN_ASIMI(8), .ADR_W(32), .VERI_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ist0_sec_i     (s0),
        .ist0_adr_i     (a0),
        .ist0_veri_i    (d0),
        .ist0_maske_i   (m0),
        .ist0_veri_o    (v0),
        .ist0_durdur_o  (dd0),
        .ist1_sec_i     (s1),
        .ist1_adr_i     (a1),
        .ist1_veri_i    (d1),
        .ist1_maske_i   (m1),
        .ist1_veri_o    (v1),
        .ist1_durdur_o  (dd1),
        .bellek_istek_o (bist),
        .bellek_adr_o   (badr),
        .bellek_veri_o  (bveri),
        .bellek_maske_o (bmaske),
        .bellek_kabul_i (kab),
        .bellek_yanit_i (yan),
        .bellek_veri_i  (md),
        .hata_o         (hata)
    );

    typedef struct packed {
        logic        s0, s1, kab, yan, boz;
        logic [31:0] md;
        logic        e_ist;
        logic [31:0] e_adr;
        logic        e_dd0, e_dd1;
        logic [31:0] e_v0, e_v1;
    } vec_t;

    vec_t tablo [38];

    function automatic vec_t mk(input logic s0_, s1_, kab_, yan_, boz_,
                                input logic [31:0] md_, input logic ist_,
                                input logic [31:0] adr_, input logic dd0_, dd1_,
                                input logic [31:0] v0_, v1_);
        vec_t v;
        v.s0 = s0_; v.s1 = s1_; v.kab = kab_; v.yan = yan_; v.boz = boz_;
        v.md = md_; v.e_ist = ist_; v.e_adr = adr_;
        v.e_dd0 = dd0_; v.e_dd1 = dd1_; v.e_v0 = v0_; v.e_v1 = v1_;
        return v;
    endfunction

    task automatic chk(input string ad, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ad, got, exp);
        end
    endtask

    // One clock: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input logic s0_, s1_, kab_, yan_, boz_, input logic [31:0] md_);
        @(posedge clk);
        #1;
        s0  = s0_;  s1  = s1_;  kab = kab_; yan = yan_; md = md_;
        a0  = boz_ ? 32'h0000_0300 : 32'h0000_0100;
        d0  = boz_ ? 32'hFFFF_FFFF : 32'h0000_00A5;
        m0  = boz_ ? 4'b1111 : 4'b0000;
        a1  = boz_ ? 32'hDEAD_0000 : 32'h0000_0200;
        d1  = boz_ ? 32'hFFFF_FFFF : 32'h1234_0000;
        m1  = boz_ ? 4'b1111 : 4'b1100;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        s0 = 0; s1 = 0; kab = 0; yan = 0; md = 0;
        a0 = 32'h100; d0 = 32'hA5; m0 = 4'b0000;
        a1 = 32'h200; d1 = 32'h1234_0000; m1 = 4'b1100;

        //                s0 s1 kb yn bz md            ist adr     dd0 dd1 v0            v1
        tablo[0]  = mk(1, 0, 0, 0, 0, 32'h0,         0, 32'h0,   1, 0, 32'h0,         32'h0);
        tablo[1]  = mk(1, 0, 0, 0, 0, 32'h0,         1, 32'h100, 1, 0, 32'h0,         32'h0);
        tablo[2]  = mk(1, 0, 1, 0, 0, 32'h0,         1, 32'h100, 1, 0, 32'h0,         32'h0);
        tablo[3]  = mk(1, 0, 0, 0, 0, 32'h0,         0, 32'h0,   1, 0, 32'h0,         32'h0);
        tablo[4]  = mk(1, 0, 0, 1, 0, 32'hCAFEBABE,  0, 32'h0,   0, 0, 32'hCAFEBABE,  32'h0);
        tablo[5]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         32'h0);
        tablo[6]  = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,   1, 1, 32'h0,         32'h0);
        tablo[7]  = mk(1, 1, 1, 1, 0, 32'h11111111,  1, 32'h200, 1, 0, 32'h0,         32'h11111111);
        tablo[8]  = mk(1, 1, 1, 1, 0, 32'h22222222,  0, 32'h0,   1, 1, 32'h0,         32'h0);
        tablo[9]  = mk(1, 1, 1, 1, 0, 32'h33333333,  1, 32'h100, 0, 1, 32'h33333333,  32'h0);
        tablo[10] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,   1, 1, 32'h0,         32'h0);
        tablo[11] = mk(1, 1, 1, 1, 0, 32'h44444444,  1, 32'h200, 1, 0, 32'h0,         32'h44444444);
        tablo[12] = mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         32'h0);
        tablo[13] = mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0,   0, 1, 32'h0,         32'h0);
        tablo[14] = mk(0, 1, 0, 0, 1, 32'h0,         1, 32'h200, 0, 1, 32'h0,         32'h0);
        tablo[15] = mk(0, 1, 0, 0, 1, 32'h0,         1, 32'h200, 0, 1, 32'h0,         32'h0);
        tablo[16] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h200, 0, 1, 32'h0,         32'h0);
        tablo[17] = mk(0, 1, 1, 0, 0, 32'h0,         1, 32'h200, 0, 1, 32'h0,         32'h0);
        tablo[18] = mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0,   0, 1, 32'h0,         32'h0);
        tablo[19] = mk(0, 1, 0, 1, 0, 32'h55555555,  0, 32'h0,   0, 0, 32'h0,         32'h55555555);
        tablo[20] = mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         32'h0);
        tablo[21] = mk(1, 0, 0, 0, 0, 32'h0,         0, 32'h0,   1, 0, 32'h0,         32'h0);
        tablo[22] = mk(1, 0, 0, 0, 0, 32'h0,         1, 32'h100, 1, 0, 32'h0,         32'h0);
        tablo[23] = mk(0, 0, 0, 0, 0, 32'h0,         1, 32'h100, 0, 0, 32'h0,         32'h0);
        tablo[24] = mk(0, 0, 0, 1, 0, 32'h99999999,  0, 32'h0,   0, 0, 32'h0,         32'h0);
        tablo[25] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,   1, 1, 32'h0,         32'h0);
        tablo[26] = mk(1, 1, 1, 1, 0, 32'h66666666,  1, 32'h100, 0, 1, 32'h66666666,  32'h0);
        tablo[27] = mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         32'h0);
        tablo[28] = mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0,   0, 1, 32'h0,         32'h0);
        tablo[29] = mk(0, 1, 1, 0, 0, 32'h0,         1, 32'h200, 0, 1, 32'h0,         32'h0);
        tablo[30] = mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         32'h0);
        tablo[31] = mk(0, 0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         32'h0);
        tablo[32] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,   1, 1, 32'h0,         32'h0);
        tablo[33] = mk(1, 1, 1, 1, 0, 32'h88888888,  1, 32'h100, 0, 1, 32'h88888888,  32'h0);
        tablo[34] = mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         32'h0);
        tablo[35] = mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0,   0, 1, 32'h0,         32'h0);
        tablo[36] = mk(0, 1, 1, 1, 0, 32'hAAAAAAAA,  1, 32'h200, 0, 0, 32'h0,         32'hAAAAAAAA);
        tablo[37] = mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_istek", {31'b0, bist}, 32'h0);
        chk("rst_adr",   badr, 32'h0);
        chk("rst_veri",  bveri, 32'h0);
        chk("rst_maske", {28'b0, bmaske}, 32'h0);
        chk("rst_hata",  {31'b0, hata}, 32'h0);
        chk("rst_dd0",   {31'b0, dd0}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 38; i++) begin
            cyc(tablo[i].s0, tablo[i].s1, tablo[i].kab, tablo[i].yan, tablo[i].boz, tablo[i].md);
            chk($sformatf("r%0d_istek", i), {31'b0, bist}, {31'b0, tablo[i].e_ist});
            chk($sformatf("r%0d_dd0", i),   {31'b0, dd0},  {31'b0, tablo[i].e_dd0});
            chk($sformatf("r%0d_dd1", i),   {31'b0, dd1},  {31'b0, tablo[i].e_dd1});
            chk($sformatf("r%0d_v0", i),    v0, tablo[i].e_v0);
            chk($sformatf("r%0d_v1", i),    v1, tablo[i].e_v1);
            chk($sformatf("r%0d_hata", i),  {31'b0, hata}, 32'h0);
            if (tablo[i].e_ist) begin
                chk($sformatf("r%0d_adr", i),   badr, tablo[i].e_adr);
                chk($sformatf("r%0d_maske", i), {28'b0, bmaske},
                    (tablo[i].e_adr == 32'h200) ? 32'hC : 32'h0);
                chk($sformatf("r%0d_bveri", i), bveri,
                    (tablo[i].e_adr == 32'h200) ? 32'h1234_0000 : 32'h0000_00A5);
            end
        end

        // Timeout: ist0 accepted, no response; oncelik is 0 coming in.
        cyc(1, 0, 0, 0, 0, 32'h0);
        chk("to_grant_dd0", {31'b0, dd0}, 32'h1);
        cyc(1, 0, 1, 0, 0, 32'h0);
        chk("to_istek", {31'b0, bist}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, (i == 7), 0, 0, 0, 32'hBAD0_BAD0);
            chk($sformatf("to_y%0d_hata", i), {31'b0, hata}, (i == 7) ? 32'h1 : 32'h0);
            chk($sformatf("to_y%0d_dd0", i),  {31'b0, dd0},  (i == 7) ? 32'h0 : 32'h1);
            chk($sformatf("to_y%0d_v0", i),   v0, 32'h0);
        end
        cyc(1, 1, 0, 0, 0, 32'h0);
        chk("to_hata_tek", {31'b0, hata}, 32'h0);
        cyc(1, 1, 0, 0, 0, 32'h0);
        chk("to_sonra_istek", {31'b0, bist}, 32'h1);
        chk("to_sonra_adr",   badr, 32'h200);

        // Async reset while ist1's write waits in YANIT.
        cyc(0, 1, 1, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 32'h0);
        chk("ar_once_maske", {28'b0, bmaske}, 32'hC);
        #2 rst = 1'b1;
        #1;
        chk("ar_adr",   badr, 32'h0);
        chk("ar_veri",  bveri, 32'h0);
        chk("ar_maske", {28'b0, bmaske}, 32'h0);
        chk("ar_istek", {31'b0, bist}, 32'h0);
        chk("ar_hata",  {31'b0, hata}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; s0 = 0; s1 = 0; yan = 1; md = 32'h7777_7777;
        @(negedge clk);
        chk("ar_yanit_v1",  v1, 32'h0);
        chk("ar_yanit_dd1", {31'b0, dd1}, 32'h0);
        chk("ar_yanit_hata", {31'b0, hata}, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        chk("ar_bos_istek", {31'b0, bist}, 32'h0);
        cyc(1, 1, 0, 0, 0, 32'h0);
        cyc(1, 1, 1, 1, 0, 32'h1357_9BDF);
        chk("ar_oncelik_adr", badr, 32'h100);
        chk("ar_oncelik_v0",  v0, 32'h1357_9BDF);
        cyc(0, 0, 0, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
